// File: rtl/mac_chain_controller.sv
// -----------------------------------------------------------------------------
// mac_chain_controller
//
// Sequencer for a chain of NUM_TAPS multiply-accumulate taps. It clears and
// loads tap coefficients from a coefficient stream, gates the chain's shared
// calculate enable from the upstream valid/ready handshake, tracks sample
// validity through the chain's fixed pipeline and presents the chain output
// with a valid/ready handshake. The data path itself is never touched.
//
// States: CLEAR -> IDLE -> (cfg_load) CLEAR -> LOAD -> RUN <-> FLUSH
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   cfg_load              pulse: reload coefficients (IDLE/RUN only)
//   cfg_flush             pulse: push zeros through the chain (RUN only)
//   s_coeff_*             coefficient stream (data/valid/last/ready)
//   coefficient_out       coefficient broadcast to every tap
//   ce_coefficient        one-hot per-tap coefficient write enable
//   reset_coefficient     clears all tap coefficients
//   s_data_valid/ready    upstream sample handshake
//   zero_data             upstream mux selects zero into the chain
//   ce_calculate          shared chain enable
//   m_data_valid/ready    chain output handshake
//   busy                  controller not in RUN
//   load_error            sticky: s_coeff_last misplaced in a reload
//
// Optional build macro MAC_CHAIN_CONTROLLER_STATS_EN adds the wrapping
// counters stat_samples (accepted samples in RUN) and stat_stalls (cycles in
// RUN with s_data_valid & ~s_data_ready). Both clear on reset and in CLEAR.
// -----------------------------------------------------------------------------
module mac_chain_controller #(
    parameter int NUM_TAPS          = 16,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int PIPELINE_LATENCY  = 18
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         cfg_load,
    input  logic                         cfg_flush,
    input  logic [COEFFICIENT_WIDTH-1:0] s_coeff_data,
    input  logic                         s_coeff_valid,
    input  logic                         s_coeff_last,
    output logic                         s_coeff_ready,
    output logic [COEFFICIENT_WIDTH-1:0] coefficient_out,
    output logic [NUM_TAPS-1:0]          ce_coefficient,
    output logic                         reset_coefficient,
    input  logic                         s_data_valid,
    output logic                         s_data_ready,
    output logic                         zero_data,
    output logic                         ce_calculate,
    output logic                         m_data_valid,
    input  logic                         m_data_ready,
    output logic                         busy,
    output logic                         load_error
`ifdef MAC_CHAIN_CONTROLLER_STATS_EN
    ,
    output logic [31:0]                  stat_samples,
    output logic [31:0]                  stat_stalls
`else
`endif
);

    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int FC_W  = $clog2(PIPELINE_LATENCY + 1);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t                         state_q,             state_d;
    logic                           load_pending_q,      load_pending_d;
    logic [IDX_W-1:0]               idx_q,               idx_d;
    logic [NUM_TAPS-1:0]            ce_coefficient_q,    ce_coefficient_d;
    logic [COEFFICIENT_WIDTH-1:0]   coefficient_out_q,   coefficient_out_d;
    logic                           reset_coefficient_q, reset_coefficient_d;
    logic                           load_error_q,        load_error_d;
    logic [PIPELINE_LATENCY-1:0]    vpipe_q,             vpipe_d;
    logic [FC_W-1:0]                flush_cnt_q,         flush_cnt_d;

    logic                           out_free_s;
    logic                           coeff_hs_s;
    logic                           last_idx_s;

    // Outputs decoded from registered state or driven straight from registers.
    assign m_data_valid      = vpipe_q[PIPELINE_LATENCY-1];
    assign out_free_s        = ~m_data_valid | m_data_ready;
    assign s_data_ready      = (state_q == ST_RUN) & out_free_s;
    assign s_coeff_ready     = (state_q == ST_LOAD);
    assign zero_data         = (state_q == ST_FLUSH);
    assign busy              = (state_q != ST_RUN);
    assign coeff_hs_s        = (state_q == ST_LOAD) & s_coeff_valid;
    assign last_idx_s        = (idx_q == IDX_W'(NUM_TAPS - 1));
    assign ce_coefficient    = ce_coefficient_q;
    assign coefficient_out   = coefficient_out_q;
    assign reset_coefficient = reset_coefficient_q;
    assign load_error        = load_error_q;

    // Shared chain enable: in RUN only on an upstream handshake, in FLUSH
    // whenever the output stage can move; frozen while output is back-pressured.
    always_comb begin
        ce_calculate = 1'b0;
        case (state_q)
            ST_RUN:   ce_calculate = s_data_valid & out_free_s;
            ST_FLUSH: ce_calculate = out_free_s;
            default:  ce_calculate = 1'b0;
        endcase
    end

    // Next-state logic for the sequencer, coefficient loader and valid pipe.
    always_comb begin
        state_d             = state_q;
        load_pending_d      = load_pending_q;
        idx_d               = idx_q;
        ce_coefficient_d    = '0;
        coefficient_out_d   = coefficient_out_q;
        load_error_d        = load_error_q;
        vpipe_d             = vpipe_q;
        flush_cnt_d         = flush_cnt_q;
        // The coefficient clear pulse follows the single CLEAR cycle.
        reset_coefficient_d = (state_q == ST_CLEAR);

        case (state_q)
            ST_CLEAR: begin
                vpipe_d     = '0;
                idx_d       = '0;
                flush_cnt_d = '0;
                if (load_pending_q) begin
                    state_d        = ST_LOAD;
                    load_pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cfg_load) begin
                    state_d        = ST_CLEAR;
                    load_pending_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (coeff_hs_s) begin
                    ce_coefficient_d  = {{(NUM_TAPS-1){1'b0}}, 1'b1} << idx_q;
                    coefficient_out_d = s_coeff_data;
                    idx_d             = idx_q + IDX_W'(1);
                    if (s_coeff_last && last_idx_s) begin
                        state_d      = ST_RUN;
                        load_error_d = 1'b0;
                    end else if (s_coeff_last || last_idx_s) begin
                        // Misplaced last: discard the partial set via CLEAR.
                        state_d        = ST_CLEAR;
                        load_pending_d = 1'b0;
                        load_error_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (cfg_load) begin
                    // Reload wins over flush; pending results are dropped now.
                    state_d        = ST_CLEAR;
                    load_pending_d = 1'b1;
                    vpipe_d        = '0;
                end else begin
                    if (ce_calculate) begin
                        vpipe_d = PIPELINE_LATENCY'({vpipe_q, 1'b1});
                    end else begin
                        vpipe_d = vpipe_q;
                    end
                    if (cfg_flush) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (ce_calculate) begin
                    vpipe_d = PIPELINE_LATENCY'({vpipe_q, 1'b0});
                    if (flush_cnt_q == FC_W'(PIPELINE_LATENCY - 1)) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FC_W'(1);
                    end
                end else begin
                    vpipe_d = vpipe_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= ST_CLEAR;
            load_pending_q      <= 1'b0;
            idx_q               <= '0;
            ce_coefficient_q    <= '0;
            coefficient_out_q   <= '0;
            reset_coefficient_q <= 1'b0;
            load_error_q        <= 1'b0;
            vpipe_q             <= '0;
            flush_cnt_q         <= '0;
        end else begin
            state_q             <= state_d;
            load_pending_q      <= load_pending_d;
            idx_q               <= idx_d;
            ce_coefficient_q    <= ce_coefficient_d;
            coefficient_out_q   <= coefficient_out_d;
            reset_coefficient_q <= reset_coefficient_d;
            load_error_q        <= load_error_d;
            vpipe_q             <= vpipe_d;
            flush_cnt_q         <= flush_cnt_d;
        end
    end

`ifdef MAC_CHAIN_CONTROLLER_STATS_EN
    logic [31:0] stat_samples_q, stat_samples_d;
    logic [31:0] stat_stalls_q,  stat_stalls_d;

    // Statistics next-state: wrapping counts, cleared while in CLEAR.
    always_comb begin
        stat_samples_d = stat_samples_q;
        stat_stalls_d  = stat_stalls_q;
        if (state_q == ST_CLEAR) begin
            stat_samples_d = 32'd0;
            stat_stalls_d  = 32'd0;
        end else if (state_q == ST_RUN) begin
            if (s_data_valid && s_data_ready) begin
                stat_samples_d = stat_samples_q + 32'd1;
            end else begin
                stat_samples_d = stat_samples_q;
            end
            if (s_data_valid && !s_data_ready) begin
                stat_stalls_d = stat_stalls_q + 32'd1;
            end else begin
                stat_stalls_d = stat_stalls_q;
            end
        end else begin
            stat_samples_d = stat_samples_q;
            stat_stalls_d  = stat_stalls_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_samples_q <= 32'd0;
            stat_stalls_q  <= 32'd0;
        end else begin
            stat_samples_q <= stat_samples_d;
            stat_stalls_q  <= stat_stalls_d;
        end
    end

    assign stat_samples = stat_samples_q;
    assign stat_stalls  = stat_stalls_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mac_chain_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mac_chain_controller (default parameters, default
// build). The reference model tracks, per chain enable, whether that enable
// accepted a real sample; a result is valid on the chain output once
// PIPELINE_LATENCY enables have been counted, acceptance enable included.
// -----------------------------------------------------------------------------
module tb_mac_chain_controller;

    localparam int N  = 16;
    localparam int CW = 16;
    localparam int L  = 18;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cfg_load, cfg_flush;
    logic [CW-1:0] s_coeff_data;
    logic          s_coeff_valid, s_coeff_last, s_coeff_ready;
    logic [CW-1:0] coefficient_out;
    logic [N-1:0]  ce_coefficient;
    logic          reset_coefficient;
    logic          s_data_valid, s_data_ready, zero_data, ce_calculate;
    logic          m_data_valid, m_data_ready, busy, load_error;

    mac_chain_controller #(.NUM_TAPS(N), .COEFFICIENT_WIDTH(CW), .PIPELINE_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_flush(cfg_flush),
        .s_coeff_data(s_coeff_data), .s_coeff_valid(s_coeff_valid),
        .s_coeff_last(s_coeff_last), .s_coeff_ready(s_coeff_ready),
        .coefficient_out(coefficient_out), .ce_coefficient(ce_coefficient),
        .reset_coefficient(reset_coefficient), .s_data_valid(s_data_valid),
        .s_data_ready(s_data_ready), .zero_data(zero_data), .ce_calculate(ce_calculate),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .busy(busy),
        .load_error(load_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int  en_cnt;
    bit  acc [0:4095];
    bit  mode_flush;
    int  flush_left;
    int  beats_act, beats_exp;

    bit   e_ce, e_sr, e_mv, e_zd;
    logic a_ce, a_sr, a_mv, a_zd;

    function automatic bit model_mv();
        if (en_cnt >= L) return acc[en_cnt - L + 1];
        return 1'b0;
    endfunction

    task automatic model_clear();
        en_cnt     = 0;
        mode_flush = 1'b0;
        flush_left = 0;
        for (int i = 0; i < 4096; i++) acc[i] = 1'b0;
    endtask

    // One RUN/FLUSH cycle: drive, compute expectation, sample at negedge, advance.
    task automatic run_cycle(input bit sv, input bit mr, input bit fl);
        bit was_flush;
        s_data_valid = sv;
        m_data_ready = mr;
        cfg_flush    = fl;
        e_mv = model_mv();
        e_zd = mode_flush;
        e_sr = !mode_flush && (!e_mv || mr);
        e_ce = mode_flush ? (!e_mv || mr) : (sv && e_sr);
        @(negedge clock);
        a_ce = ce_calculate; a_sr = s_data_ready; a_mv = m_data_valid; a_zd = zero_data;
        if (a_mv && mr) beats_act++;
        if (e_mv && mr) beats_exp++;
        was_flush = mode_flush;
        if (e_ce) begin
            en_cnt++;
            acc[en_cnt] = !was_flush;
            if (was_flush) begin
                flush_left--;
                if (flush_left == 0) mode_flush = 1'b0;
            end
        end
        if (fl && !was_flush) begin
            mode_flush = 1'b1;
            flush_left = L;
        end
        @(posedge clock); #1;
        cfg_flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] got, want;
        int rc_cnt;
        reset_n = 1'b0; cfg_load = 0; cfg_flush = 0; s_coeff_data = '0;
        s_coeff_valid = 0; s_coeff_last = 0; s_data_valid = 1; m_data_ready = 1;
        repeat (3) @(posedge clock);
        #1;
        got  = {ce_coefficient, reset_coefficient, ce_calculate, s_coeff_ready, s_data_ready,
                zero_data, m_data_valid, load_error, busy, coefficient_out};
        want = {16'h0000, 8'b0000_0001, 16'h0000};
        n_checks++;
        if (got !== want) $display("FAIL reset_values: got %h expected %h", got, want);
        else n_pass++;
        s_data_valid = 0; m_data_ready = 0;
        reset_n = 1'b1;
        rc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (reset_coefficient === 1'b1) rc_cnt++;
        end
        n_checks++;
        if (rc_cnt !== 1) $display("FAIL reset_clear_pulse: got %0d cycles expected 1", rc_cnt);
        else n_pass++;
        n_checks++;
        if ({busy, s_coeff_ready, ce_coefficient, ce_calculate} !== {1'b1, 1'b0, 16'h0000, 1'b0})
            $display("FAIL reset_idle: got busy=%b rdy=%b ce=%h cc=%b expected 1 0 0000 0",
                     busy, s_coeff_ready, ce_coefficient, ce_calculate);
        else n_pass++;
    endtask

    // Reload coefficients; last_at = position (1-based) of s_coeff_last, 0 = none.
    task automatic load_coeffs(input int last_at, input bit seq, input bit with_flush);
        logic [CW-1:0] data;
        logic [N-1:0]  one_hot;
        int waited;
        cfg_load = 1'b1; cfg_flush = with_flush;
        s_data_valid = 1'b0; m_data_ready = 1'b0;
        @(posedge clock); #1;
        cfg_load = 1'b0; cfg_flush = 1'b0;
        n_checks++;
        if (m_data_valid !== 1'b0) $display("FAIL load_drop_valid: got %b expected 0", m_data_valid);
        else n_pass++;
        model_clear();
        for (int i = 0; i < N; i++) begin
            data = seq ? CW'(i + 1) : CW'($urandom);
            s_coeff_data = data; s_coeff_valid = 1'b1; s_coeff_last = (i + 1 == last_at);
            waited = 0;
            while (s_coeff_ready !== 1'b1 && waited < 8) begin
                @(posedge clock); #1;
                waited++;
            end
            n_checks++;
            if (s_coeff_ready !== 1'b1) begin
                $display("FAIL load_ready_timeout: got %b expected 1", s_coeff_ready);
                s_coeff_valid = 1'b0;
                return;
            end else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (zero_data !== 1'b0) $display("FAIL load_not_flush: got %b expected 0", zero_data);
                else n_pass++;
            end
            @(posedge clock); #1;
            one_hot = N'(1) << i;
            n_checks++;
            if (ce_coefficient !== one_hot || coefficient_out !== data)
                $display("FAIL load_tap%0d: got ce=%h data=%h expected ce=%h data=%h",
                         i, ce_coefficient, coefficient_out, one_hot, data);
            else n_pass++;
            if (s_coeff_last) break;
            if (i < N - 1 && $urandom_range(0, 3) == 0) begin
                s_coeff_valid = 1'b0;
                @(posedge clock); #1;
                n_checks++;
                if (ce_coefficient !== 16'h0000)
                    $display("FAIL load_stall: got ce=%h expected 0000", ce_coefficient);
                else n_pass++;
            end
        end
        s_coeff_valid = 1'b0; s_coeff_last = 1'b0;
        if (last_at == N) begin
            n_checks++;
            if ({busy, load_error} !== 2'b00)
                $display("FAIL load_to_run: got busy=%b err=%b expected 0 0", busy, load_error);
            else n_pass++;
        end else begin
            n_checks++;
            if ({busy, load_error} !== 2'b11)
                $display("FAIL load_error_set: got busy=%b err=%b expected 1 1", busy, load_error);
            else n_pass++;
            @(posedge clock); #1;
            n_checks++;
            if (reset_coefficient !== 1'b1)
                $display("FAIL load_error_clear: got %b expected 1", reset_coefficient);
            else n_pass++;
            @(posedge clock); #1;
            n_checks++;
            if ({reset_coefficient, s_coeff_ready, busy} !== 3'b001)
                $display("FAIL load_error_idle: got rc=%b rdy=%b busy=%b expected 0 0 1",
                         reset_coefficient, s_coeff_ready, busy);
            else n_pass++;
        end
    endtask

    task automatic test_load_ok();
        load_coeffs(N, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first_k;
        beats_act = 0; beats_exp = 0; first_k = -1;
        for (int k = 0; k < 20; k++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({a_ce, a_sr, a_mv} !== {e_ce, e_sr, e_mv})
                $display("FAIL b2b_cycle%0d: got ce/sr/mv=%b%b%b expected %b%b%b",
                         k, a_ce, a_sr, a_mv, e_ce, e_sr, e_mv);
            else n_pass++;
            if (a_mv === 1'b1 && first_k < 0) first_k = k;
        end
        n_checks++;
        if (first_k !== L) $display("FAIL b2b_first_valid: got enable %0d expected %0d", first_k, L);
        else n_pass++;
        n_checks++;
        if (beats_act !== 2) $display("FAIL b2b_beats: got %0d expected 2", beats_act);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            run_cycle(1'b0, 1'b0, 1'b0);
            n_checks++;
            if ({a_ce, a_mv} !== {e_ce, e_mv})
                $display("FAIL b2b_hold%0d: got ce/mv=%b%b expected %b%b", k, a_ce, a_mv, e_ce, e_mv);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit sv, mr;
        beats_act = 0; beats_exp = 0;
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({a_ce, a_sr, a_mv} !== 3'b001)
                $display("FAIL bp_freeze%0d: got ce/sr/mv=%b%b%b expected 001", k, a_ce, a_sr, a_mv);
            else n_pass++;
        end
        for (int k = 0; k < 80; k++) begin
            sv = 1'($urandom_range(0, 1));
            mr = sv & 1'($urandom_range(0, 1));
            run_cycle(sv, mr, 1'b0);
            n_checks++;
            if ({a_ce, a_sr, a_mv} !== {e_ce, e_sr, e_mv})
                $display("FAIL bp_cycle%0d: got ce/sr/mv=%b%b%b expected %b%b%b",
                         k, a_ce, a_sr, a_mv, e_ce, e_sr, e_mv);
            else n_pass++;
        end
        n_checks++;
        if (beats_act !== beats_exp) $display("FAIL bp_beats: got %0d expected %0d", beats_act, beats_exp);
        else n_pass++;
    endtask

    task automatic test_load_error();
        load_coeffs(5, 1'b0, 1'b0);
        load_coeffs(0, 1'b0, 1'b0);
        load_coeffs(N, 1'b0, 1'b1);
        n_checks++;
        if (load_error !== 1'b0) $display("FAIL load_error_cleared: got %b expected 0", load_error);
        else n_pass++;
    endtask

    task automatic test_flush();
        int zcnt;
        beats_act = 0; beats_exp = 0; zcnt = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({a_ce, a_sr, a_mv, a_zd} !== {e_ce, e_sr, e_mv, e_zd})
                $display("FAIL flush_pre%0d: got %b%b%b%b expected %b%b%b%b",
                         k, a_ce, a_sr, a_mv, a_zd, e_ce, e_sr, e_mv, e_zd);
            else n_pass++;
        end
        run_cycle(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 80 && mode_flush; k++) begin
            run_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
            n_checks++;
            if ({a_ce, a_sr, a_mv, a_zd} !== {e_ce, e_sr, e_mv, e_zd})
                $display("FAIL flush_cycle%0d: got ce/sr/mv/zd=%b%b%b%b expected %b%b%b%b",
                         k, a_ce, a_sr, a_mv, a_zd, e_ce, e_sr, e_mv, e_zd);
            else n_pass++;
            if (a_zd === 1'b1 && a_ce === 1'b1) zcnt++;
        end
        n_checks++;
        if (zcnt !== L) $display("FAIL flush_enables: got %0d expected %0d", zcnt, L);
        else n_pass++;
        n_checks++;
        if (beats_act !== 3) $display("FAIL flush_beats: got %0d expected 3", beats_act);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({a_zd, a_sr, a_ce} !== 3'b011)
                $display("FAIL flush_back_to_run%0d: got zd/sr/ce=%b%b%b expected 011", k, a_zd, a_sr, a_ce);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int rc_cnt;
        for (int k = 0; k < 20; k++) run_cycle(1'b1, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({m_data_valid, busy, ce_calculate, s_data_ready, load_error} !== 5'b01000)
            $display("FAIL reset_mid_async: got mv/busy/ce/sr/err=%b%b%b%b%b expected 01000",
                     m_data_valid, busy, ce_calculate, s_data_ready, load_error);
        else n_pass++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        s_data_valid = 1'b0;
        rc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (reset_coefficient === 1'b1) rc_cnt++;
        end
        n_checks++;
        if (rc_cnt !== 1 || busy !== 1'b1)
            $display("FAIL reset_mid_clear: got pulses=%0d busy=%b expected 1 1", rc_cnt, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_ok();
        test_back_to_back();
        test_backpressure();
        test_load_error();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
